// File: rtl/seg_display_scheduler_pkg.sv
// Shared types and sizing helpers for the seven-segment debug scheduler.
package seg_sched_pkg;

  // Display phases of one source's turn.
  typedef enum logic [1:0] {
    SHOW_LO = 2'd0,
    SHOW_HI = 2'd1,
    BLANK   = 2'd2
  } state_t;

  // Index width for a round-robin over n sources (never zero).
  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Timer width large enough to count 0..max(dwell, blank_cycles)-1.
  function automatic int timer_width(int dwell, int blank_cycles);
    int m;
    m = (dwell > blank_cycles) ? dwell : blank_cycles;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/seg_display_scheduler_if.sv
// Bundle between the debug taps / control and the scheduler, plus the
// display-side outputs consumed by the 7-seg driver.
interface seg_display_scheduler_if
  import seg_sched_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int WIDTH   = 32
);
  localparam int IDX_W = idx_width(NUM_SRC);

  logic [NUM_SRC*WIDTH-1:0] src_data;
  logic [NUM_SRC-1:0]       src_en;
  logic                     hold;
  logic                     step;
  logic [15:0]              disp_half;
  logic                     half_hi;
  logic                     blank;
  logic [IDX_W-1:0]         src_idx;
  logic                     turn_start;

  // Source/control side: drives the taps, watches the display outputs.
  modport master (
    output src_data, src_en, hold, step,
    input  disp_half, half_hi, blank, src_idx, turn_start
  );

  // Scheduler side.
  modport slave (
    input  src_data, src_en, hold, step,
    output disp_half, half_hi, blank, src_idx, turn_start
  );
endinterface

// File: rtl/seg_rr_pick.sv
// Combinational round-robin pick: first set mask bit after 'last',
// wrapping; returns 'last' itself when it is the only enabled bit.
module seg_rr_pick
  import seg_sched_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] nxt,
  output logic          any
);

  // Scan offsets 1..N from last; the nearest enabled successor wins.
  always_comb begin
    int   j;
    logic found;
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    nxt   = last;
    found = 1'b0;
    j     = 0;
    for (int i = 1; i <= N; i++) begin
      j = int'(last) + i;
      if (j >= N) j -= N;
      if (!found && mask[IW'(j)]) begin
        nxt   = IW'(j);
        found = 1'b1;
      end
    end
  end

  assign any = |mask;

endmodule

// File: rtl/seg_display_scheduler.sv
// Time-shares a 4-digit seven-segment display among NUM_SRC debug words:
// each enabled source shows its low half, its high half, then a blank gap.
module seg_display_scheduler
  import seg_sched_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int NUM_SRC      = 4,
  parameter int DWELL_CYCLES = 50000000,
  parameter int BLANK_CYCLES = 5000000
) (
  input  logic                     clk,
  input  logic                     rst,
  seg_display_scheduler_if.slave   bus
);

  localparam int IDX_W = idx_width(NUM_SRC);
  localparam int TW    = timer_width(DWELL_CYCLES, BLANK_CYCLES);

  state_t             state;
  logic [TW-1:0]      timer;
  logic [WIDTH-1:0]   snap;
  logic [IDX_W-1:0]   src_idx;
  logic [15:0]        disp_half;
  logic               half_hi;
  logic               blank;
  logic               turn_start;

  logic [TW-1:0]      last_count;
  logic               tc;
  logic               adv;
  logic [IDX_W-1:0]   nxt;
  logic               any;
  logic [WIDTH-1:0]   nxt_word;

  seg_rr_pick #(.N(NUM_SRC)) u_pick (
    .mask (bus.src_en),
    .last (src_idx),
    .nxt  (nxt),
    .any  (any)
  );

  // Terminal count depends on the phase; hold suppresses it, step does not.
  assign last_count = (state == BLANK) ? TW'(BLANK_CYCLES - 1) : TW'(DWELL_CYCLES - 1);
  assign tc         = !bus.hold && (timer == last_count);
  assign adv        = tc || bus.step;
  assign nxt_word   = bus.src_data[int'(nxt) * WIDTH +: WIDTH];

  // Phase FSM with timer, snapshot and registered display outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the snapshot is a plain register, so it is reset with everything else.
      state      <= BLANK;
      timer      <= '0;
      snap       <= '0;
      src_idx    <= IDX_W'(NUM_SRC - 1);
      disp_half  <= '0;
      half_hi    <= 1'b0;
      blank      <= 1'b1;
      turn_start <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      turn_start <= 1'b0;
      case (state)
        SHOW_LO, SHOW_HI: begin
          // Losing the shown source aborts the turn; a single adv moves one phase.
          if (!bus.src_en[src_idx] || (adv && state == SHOW_HI)) begin
            state     <= BLANK;
            timer     <= '0;
            blank     <= 1'b1;
            half_hi   <= 1'b0;
            disp_half <= '0;
          end else if (adv) begin
            state     <= SHOW_HI;
            timer     <= '0;
            half_hi   <= 1'b1;
            disp_half <= snap[31:16];
          end else begin
            if (!bus.hold) timer <= timer + 1'b1;
            disp_half <= (state == SHOW_LO) ? snap[15:0] : snap[31:16];
          end
        end
        BLANK: begin
          // Start the next turn only when something is enabled; else keep wrapping.
          if (adv && any) begin
            state      <= SHOW_LO;
            timer      <= '0;
            snap       <= nxt_word;
            src_idx    <= nxt;
            disp_half  <= nxt_word[15:0];
            half_hi    <= 1'b0;
            blank      <= 1'b0;
            turn_start <= 1'b1;
          end else if (!bus.hold) begin
            timer <= tc ? '0 : timer + 1'b1;
          end
        end
        default: begin
          state     <= BLANK;
          timer     <= '0;
          blank     <= 1'b1;
          half_hi   <= 1'b0;
          disp_half <= '0;
        end
      endcase
    end
  end

  assign bus.disp_half  = disp_half;
  assign bus.half_hi    = half_hi;
  assign bus.blank      = blank;
  assign bus.src_idx    = src_idx;
  assign bus.turn_start = turn_start;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed bench for seg_display_scheduler: expected per-cycle outputs are
// queued as stimulus is driven and popped one per clock as the DUT runs.
module tb_seg_display_scheduler;
  localparam int NUM_SRC = 4;
  localparam int WIDTH   = 32;
  localparam int DWELL   = 4;
  localparam int BLANKC  = 2;

  typedef struct packed {
    logic        blank;
    logic        half_hi;
    logic [1:0]  idx;
    logic [15:0] disp;
    logic        ts;
  } pkt_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    checks = 0;
  int    errors = 0;
  string phase  = "reset";
  pkt_t  exp_q[$];

  localparam logic [31:0] W0 = 32'h1234_ABCD;
  localparam logic [31:0] W1 = 32'h5678_0001;
  localparam logic [31:0] W2 = 32'h9ABC_0002;
  localparam logic [31:0] W3 = 32'hDEF0_0003;
  localparam logic [31:0] WN = 32'hFFFF_0000;

  seg_display_scheduler_if #(.NUM_SRC(NUM_SRC), .WIDTH(WIDTH)) bus ();

  seg_display_scheduler #(
    .WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANKC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic pkt_t observed();
    return '{blank: bus.blank, half_hi: bus.half_hi, idx: bus.src_idx,
             disp: bus.disp_half, ts: bus.turn_start};
  endfunction

  function automatic pkt_t lo(logic [1:0] i, logic [31:0] w, logic ts);
    return '{blank: 1'b0, half_hi: 1'b0, idx: i, disp: w[15:0], ts: ts};
  endfunction

  function automatic pkt_t hi(logic [1:0] i, logic [31:0] w);
    return '{blank: 1'b0, half_hi: 1'b1, idx: i, disp: w[31:16], ts: 1'b0};
  endfunction

  function automatic pkt_t blk(logic [1:0] i);
    return '{blank: 1'b1, half_hi: 1'b0, idx: i, disp: 16'h0000, ts: 1'b0};
  endfunction

  task automatic check(string tag, pkt_t obs, pkt_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed blank=%b hi=%b idx=%0d disp=%h ts=%b, expected blank=%b hi=%b idx=%0d disp=%h ts=%b",
             tag, obs.blank, obs.half_hi, obs.idx, obs.disp, obs.ts,
             exp.blank, exp.half_hi, exp.idx, exp.disp, exp.ts);
    end
  endtask

  task automatic push(int n, pkt_t p);
    for (int k = 0; k < n; k++) exp_q.push_back(p);
  endtask

  // One complete turn: LO for DWELL (first cycle pulses turn_start), HI for DWELL, BLANK gap.
  task automatic push_turn(logic [1:0] i, logic [31:0] w);
    push(1, lo(i, w, 1'b1));
    push(DWELL - 1, lo(i, w, 1'b0));
    push(DWELL, hi(i, w));
    push(BLANKC, blk(i));
  endtask

  // Pop one expectation per clock, sampled 1 time unit after the edge.
  task automatic drain();
    pkt_t p;
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      p = exp_q.pop_front();
      check(phase, observed(), p);
    end
  endtask

  initial begin
    bus.hold     = 1'b0;
    bus.step     = 1'b0;
    bus.src_en   = 4'b1111;
    bus.src_data = {W3, W2, W1, W0};

    // Reset state while rst is held.
    #12;
    check("reset_state", observed(), blk(2'd3));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // First turn after reset, then full rotation 0..3 and back to 0.
    phase = "free_run";
    push(1, blk(2'd3));
    push_turn(2'd0, W0);
    push_turn(2'd1, W1);
    push_turn(2'd2, W2);
    push_turn(2'd3, W3);
    push(1, lo(2'd0, W0, 1'b1));
    push(1, lo(2'd0, W0, 1'b0));
    drain();

    // Source changes mid-turn are not reflected in the current snapshot.
    phase = "snapshot_stable";
    bus.src_data[31:0] = WN;
    push(2, lo(2'd0, W0, 1'b0));
    push(2, hi(2'd0, W0));
    drain();

    // Mask 0101 from here: rotation becomes 0,2,0,2.
    phase = "mask_0101";
    bus.src_en = 4'b0101;
    push(2, hi(2'd0, W0));
    push(BLANKC, blk(2'd0));
    push_turn(2'd2, W2);
    push_turn(2'd0, WN);
    push(DWELL, lo(2'd2, W2, 1'b0));
    exp_q[exp_q.size() - DWELL].ts = 1'b1;
    push(DWELL, hi(2'd2, W2));
    push(1, blk(2'd2));
    drain();

    // All sources disabled: blank indefinitely, index held.
    phase = "mask_zero";
    bus.src_en = 4'b0000;
    push(26, blk(2'd2));
    drain();

    // Re-enable everything: next pick after index 2 is 3.
    phase = "reenable";
    bus.src_en = 4'b1111;
    push(1, blk(2'd2));
    push(1, lo(2'd3, W3, 1'b1));
    push(1, lo(2'd3, W3, 1'b0));
    drain();

    // Hold freezes the LO phase.
    phase = "hold";
    bus.hold = 1'b1;
    push(20, lo(2'd3, W3, 1'b0));
    drain();

    // Single step while held advances exactly one phase.
    phase = "step_in_hold";
    bus.step = 1'b1;
    push(1, hi(2'd3, W3));
    drain();
    bus.step = 1'b0;
    bus.hold = 1'b0;

    // Step coincident with terminal count: one advance only.
    phase = "step_at_tc";
    push(DWELL - 1, hi(2'd3, W3));
    drain();
    bus.step = 1'b1;
    push(1, blk(2'd3));
    drain();
    bus.step = 1'b0;
    push(1, blk(2'd3));
    push(1, lo(2'd0, WN, 1'b1));
    push(DWELL - 1, lo(2'd0, WN, 1'b0));
    push(2, hi(2'd0, WN));
    drain();

    // Dropping the shown source mid-HI blanks on the next cycle.
    phase = "drop_source";
    bus.src_en = 4'b1110;
    push(1, blk(2'd0));
    push(1, blk(2'd0));
    push(1, lo(2'd1, W1, 1'b1));
    push(1, lo(2'd1, W1, 1'b0));
    drain();

    // Asynchronous reset mid-LO, away from any clock edge.
    #3;
    rst = 1'b1;
    #1;
    check("async_reset", observed(), blk(2'd3));
    bus.src_en = 4'b1111;
    @(posedge clk);
    #1;
    check("reset_held", observed(), blk(2'd3));
    rst = 1'b0;

    phase = "after_reset";
    push(1, blk(2'd3));
    push(1, lo(2'd0, WN, 1'b1));
    push(DWELL - 1, lo(2'd0, WN, 1'b0));
    push(1, hi(2'd0, WN));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
